grid_solve_ctrl: RTL and testbench

//  Parametrised sequencer and I/O front-end for a tile-chain sudoku solver of any order.

---
 rtl/grid_pkg.sv | 44 ++++
 rtl/grid_solve_ctrl_onehot_enc.sv | 20 ++
 rtl/grid_solve_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_grid_solve_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the grid solver front-end and tile array:
// grid geometry, controller state encoding and one-hot/binary helpers.
package grid_pkg;

  // Widest digit vector the helpers handle (order 8 grids).
  localparam int MAX_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KICK    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SOLVED  = 3'd3,
    ST_FAILED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  function automatic int grid_len(input int ord);
    return ord * ord;
  endfunction

  function automatic int grid_area(input int ord);
    return ord * ord * ord * ord;
  endfunction

  // Digit 1..MAX_LEN to one-hot; 0 (empty) or out of range gives all zeros.
  function automatic logic [MAX_LEN-1:0] bin2onehot(input int unsigned v);
    logic [MAX_LEN-1:0] r;
    for (int i = 0; i < MAX_LEN; i++) r[i] = (v == unsigned'(i + 1));
    return r;
  endfunction

  // One-hot to digit (bit i -> i+1); 0 when no bit is set.
  function automatic int unsigned onehot2bin(input logic [MAX_LEN-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = MAX_LEN - 1; i >= 0; i--) if (oh[i]) r = unsigned'(i + 1);
    return r;
  endfunction

  function automatic logic is_onehot(input logic [MAX_LEN-1:0] v);
    return (v != '0) && ((v & (v - MAX_LEN'(1))) == '0);
  endfunction

endpackage

// File: rtl/grid_solve_ctrl_onehot_enc.sv
// One-hot tile value to binary digit; anything not exactly one-hot
// encodes as 0 with valid low.
module onehot_enc
  import grid_pkg::*;
#(
  parameter int LEN = 9,
  parameter int VW  = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0] oh,
  output logic [VW-1:0]  bin,
  output logic           valid
);

  logic [MAX_LEN-1:0] oh_ext;

  assign oh_ext = MAX_LEN'(oh);
  assign valid  = is_onehot(oh_ext);
  assign bin    = valid ? VW'(onehot2bin(oh_ext)) : '0;

endmodule

// File: rtl/grid_solve_ctrl.sv
// Sequencer for the tile-chain solver: loads givens, kicks the chain,
// watches for solve/fail/timeout and streams the solved grid back out.
module grid_solve_ctrl
  import grid_pkg::*;
#(
  parameter  int ORD        = 3,
  parameter  int MAX_CYCLES = 2**20,
  parameter  int CYC_W      = 32,
  localparam int LEN        = grid_len(ORD),
  localparam int AREA       = grid_area(ORD),
  localparam int VW         = $clog2(LEN + 1),
  localparam int IW         = $clog2(AREA)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [VW-1:0]       ld_value,
  input  logic                start,
  input  logic                clear,
  output logic                chain_kick,
  output logic                chain_clear,
  input  logic                chain_passbak,
  input  logic                chain_passfwd,
  output logic [AREA-1:0]     given_mask,
  output logic [AREA*LEN-1:0] given_value,
  input  logic [AREA*LEN-1:0] tile_values,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [VW-1:0]       rd_value,
  output logic                rd_last,
  output logic                done,
  output logic                success,
  output logic                timeout,
  output logic                err,
  output logic [CYC_W-1:0]    cycles
);

  // Load index must be able to reach AREA (the "full" value).
  localparam int LW = $clog2(AREA + 1);

  state_e              state_q, state_d;
  logic [LW-1:0]       ld_idx_q, ld_idx_d;
  logic [AREA-1:0]     given_mask_q, given_mask_d;
  logic [AREA*LEN-1:0] given_value_q, given_value_d;
  logic                err_q, err_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;
  logic [IW-1:0]       rd_idx_q, rd_idx_d;
  logic                rd_valid_q, rd_valid_d;
  logic [VW-1:0]       rd_value_q, rd_value_d;
  logic                rd_done_q, rd_done_d;
  logic                chain_clear_q, chain_clear_d;

  logic                ld_hs, rd_hs, rd_at_last, ld_bad, ld_fixed;
  logic [IW-1:0]       ld_cell, fetch_idx;
  logic [LEN-1:0]      fetch_cell;
  logic [VW-1:0]       enc_bin;
  logic                enc_ok;

  assign ld_ready   = (state_q == ST_IDLE) && (ld_idx_q < LW'(AREA));
  assign ld_hs      = ld_valid && ld_ready;
  assign ld_cell    = ld_idx_q[IW-1:0];
  assign ld_bad     = ld_value > VW'(LEN);
  assign ld_fixed   = (ld_value != '0) && !ld_bad;
  assign rd_hs      = rd_valid_q && rd_ready;
  assign rd_at_last = rd_idx_q == IW'(AREA - 1);
  // On an accepted beat the next cell is fetched so beats can go back-to-back.
  assign fetch_idx  = (rd_hs && !rd_at_last) ? rd_idx_q + IW'(1) : rd_idx_q;
  assign fetch_cell = tile_values[int'(fetch_idx)*LEN +: LEN];

  onehot_enc #(.LEN(LEN), .VW(VW)) u_enc (
    .oh    (fetch_cell),
    .bin   (enc_bin),
    .valid (enc_ok)
  );

  // Next-state: clear overrides everything, then per-state load/solve/readout.
  always_comb begin
    state_d       = state_q;
    ld_idx_d      = ld_idx_q;
    given_mask_d  = given_mask_q;
    given_value_d = given_value_q;
    err_d         = err_q;
    cycles_d      = cycles_q;
    rd_idx_d      = rd_idx_q;
    rd_valid_d    = rd_valid_q;
    rd_value_d    = rd_value_q;
    rd_done_d     = rd_done_q;
    chain_clear_d = 1'b0;
    if (clear) begin
      state_d       = ST_IDLE;
      ld_idx_d      = '0;
      given_mask_d  = '0;
      given_value_d = '0;
      err_d         = 1'b0;
      cycles_d      = '0;
      rd_idx_d      = '0;
      rd_valid_d    = 1'b0;
      rd_value_d    = '0;
      rd_done_d     = 1'b0;
      chain_clear_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_hs) begin
            given_mask_d[ld_cell] = ld_fixed;
            given_value_d[int'(ld_cell)*LEN +: LEN] = LEN'(bin2onehot(32'(ld_value)));
            if (ld_bad) err_d = 1'b1;
            ld_idx_d = ld_idx_q + LW'(1);
          end
          if (start) state_d = ST_KICK;
        end
        ST_KICK: begin
          cycles_d = '0;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          // The exit cycle is not counted, so cycles reads the WAIT index of the event.
          if (chain_passbak)      state_d = ST_FAILED;
          else if (chain_passfwd) state_d = ST_SOLVED;
          else if (MAX_CYCLES != 0 && cycles_q == CYC_W'(MAX_CYCLES - 1))
                                  state_d = ST_TIMEOUT;
          else if (cycles_q != '1) cycles_d = cycles_q + CYC_W'(1);
        end
        default: begin
          if ((!rd_valid_q && !rd_done_q) || (rd_hs && !rd_at_last)) begin
            rd_idx_d   = fetch_idx;
            rd_valid_d = 1'b1;
            rd_value_d = enc_bin;
            if (!enc_ok) err_d = 1'b1;
          end else if (rd_hs) begin
            rd_valid_d = 1'b0;
            rd_done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ld_idx_q      <= '0;
      given_mask_q  <= '0;
      given_value_q <= '0;
      err_q         <= 1'b0;
      cycles_q      <= '0;
      rd_idx_q      <= '0;
      rd_valid_q    <= 1'b0;
      rd_value_q    <= '0;
      rd_done_q     <= 1'b0;
      chain_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_idx_q      <= ld_idx_d;
      given_mask_q  <= given_mask_d;
      given_value_q <= given_value_d;
      err_q         <= err_d;
      cycles_q      <= cycles_d;
      rd_idx_q      <= rd_idx_d;
      rd_valid_q    <= rd_valid_d;
      rd_value_q    <= rd_value_d;
      rd_done_q     <= rd_done_d;
      chain_clear_q <= chain_clear_d;
    end
  end

  assign chain_kick  = state_q == ST_KICK;
  assign chain_clear = chain_clear_q;
  assign given_mask  = given_mask_q;
  assign given_value = given_value_q;
  assign rd_valid    = rd_valid_q;
  assign rd_value    = rd_value_q;
  assign rd_last     = rd_valid_q && rd_at_last;
  assign success     = state_q == ST_SOLVED;
  assign timeout     = state_q == ST_TIMEOUT;
  assign done        = (state_q == ST_SOLVED) || (state_q == ST_FAILED) || (state_q == ST_TIMEOUT);
  assign err         = err_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_grid_solve_ctrl.sv
// Directed/randomized bench for grid_solve_ctrl at order 2 with a 10-cycle budget.
module tb_grid_solve_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [2:0]  ld_value = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        chain_kick, chain_clear;
  logic        chain_passbak = 1'b0;
  logic        chain_passfwd = 1'b0;
  logic [15:0] given_mask;
  logic [63:0] given_value;
  logic [63:0] tile_values = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [2:0]  rd_value;
  logic        rd_last, done, success, timeout, err;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  // reference model: loaded digits, load count, sticky error, tile contents
  int         gv[16];
  int         n_ld;
  bit         err_m;
  logic [3:0] tv[16];

  grid_solve_ctrl #(.ORD(2), .MAX_CYCLES(10), .CYC_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_value(ld_value), .start(start), .clear(clear), .chain_kick(chain_kick),
    .chain_clear(chain_clear), .chain_passbak(chain_passbak), .chain_passfwd(chain_passfwd),
    .given_mask(given_mask), .given_value(given_value), .tile_values(tile_values),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_value(rd_value), .rd_last(rd_last),
    .done(done), .success(success), .timeout(timeout), .err(err), .cycles(cycles)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_mask();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (gv[i] != 0);
    return m;
  endfunction

  function automatic logic [63:0] exp_value();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) if (gv[i] != 0) v[i*4 + gv[i] - 1] = 1'b1;
    return v;
  endfunction

  function automatic int exp_digit(input logic [3:0] t);
    if ($countones(t) != 1) return 0;
    for (int i = 0; i < 4; i++) if (t[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) gv[i] = 0;
    n_ld  = 0;
    err_m = 1'b0;
  endtask

  task automatic load(input logic [2:0] v, input bit with_start);
    ld_valid = 1'b1;
    ld_value = v;
    start    = with_start;
    if (n_ld < 16) begin
      if (v > 4) begin
        err_m = 1'b1;
        gv[n_ld] = 0;
      end else gv[n_ld] = int'(v);
      n_ld++;
    end
    step();
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic set_tiles(input int bad_cell);
    for (int i = 0; i < 16; i++) begin
      tv[i] = 4'b0001 << $urandom_range(0, 3);
      if (i == bad_cell) tv[i] = 4'b0110;
      tile_values[i*4 +: 4] = tv[i];
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    chk("clr_pulse", chain_clear, 1);
    chk("clr_done", done, 0);
    chk("clr_ld_ready", ld_ready, 1);
    step();
    chk("clr_pulse_end", chain_clear, 0);
  endtask

  // start from IDLE, land in WAIT cycle 0
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("kick_pulse", chain_kick, 1);
    step();
    chk("wait_c0", cycles, 0);
  endtask

  task automatic readout(input bit toggle);
    int beats = 0;
    int budget = 0;
    rd_ready = ~toggle;
    while (beats < 16 && budget < 200) begin
      if (toggle) rd_ready = ~rd_ready;
      if (rd_valid) begin
        chk("rd_value", rd_value, exp_digit(tv[beats]));
        chk("rd_last", rd_last, beats == 15);
        if (rd_ready) beats++;
      end
      step();
      budget++;
    end
    chk("rd_beats", beats, 16);
    chk("rd_valid_after", rd_valid, 0);
    step();
    chk("rd_valid_stays", rd_valid, 0);
    rd_ready = 1'b0;
  endtask

  initial begin
    model_clear();
    step();
    step();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_mask", given_mask, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_chain_clear", chain_clear, 0);
    #2 reset_n = 1'b1;
    step();

    // full load, solved at WAIT cycle 5, full-speed readout
    for (int i = 0; i < 16; i++) load(3'($urandom_range(0, 4)), 1'b0);
    chk("full_ld_ready", ld_ready, 0);
    load(3'd3, 1'b0);
    chk("full_mask", given_mask, exp_mask());
    chk("full_value", given_value, exp_value());
    set_tiles(-1);
    kick();
    repeat (5) step();
    chk("wait_c5", cycles, 5);
    chain_passfwd = 1'b1;
    step();
    chain_passfwd = 1'b0;
    chk("solved_success", success, 1);
    chk("solved_done", done, 1);
    chk("solved_cycles", cycles, 5);
    chk("solved_rd_lat", rd_valid, 0);
    readout(1'b0);
    chk("solved_err", err, 0);
    chk("solved_hold_value", given_value, exp_value());

    // three loads (last with start), failed; stalled readout with a bad tile
    do_clear();
    load(3'($urandom_range(1, 4)), 1'b0);
    load(3'($urandom_range(1, 4)), 1'b0);
    load(3'($urandom_range(1, 4)), 1'b1);
    chk("kick_with_load", chain_kick, 1);
    chk("three_mask", given_mask, 16'h0007);
    chk("three_value", given_value, exp_value());
    step();
    step();
    set_tiles(2);
    chain_passbak = 1'b1;
    step();
    chain_passbak = 1'b0;
    chk("failed_done", done, 1);
    chk("failed_success", success, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored", done, 1);
    readout(1'b1);
    err_m = 1'b1;
    chk("bad_tile_err", err, err_m);

    // timeout after cycles==9
    do_clear();
    kick();
    repeat (9) step();
    chk("to_c9", cycles, 9);
    chk("to_not_yet", done, 0);
    step();
    chk("to_timeout", timeout, 1);
    chk("to_done", done, 1);
    chk("to_success", success, 0);
    chk("to_cycles", cycles, 9);

    // passfwd on the last budget cycle wins
    do_clear();
    kick();
    repeat (9) step();
    chain_passfwd = 1'b1;
    step();
    chain_passfwd = 1'b0;
    chk("edge_success", success, 1);
    chk("edge_timeout", timeout, 0);

    // both chain inputs together -> failed
    do_clear();
    kick();
    repeat (3) step();
    chain_passbak = 1'b1;
    chain_passfwd = 1'b1;
    step();
    chain_passbak = 1'b0;
    chain_passfwd = 1'b0;
    chk("both_done", done, 1);
    chk("both_success", success, 0);

    // clear in the middle of WAIT
    do_clear();
    kick();
    repeat ($urandom_range(1, 6)) step();
    clear = 1'b1;
    chain_passfwd = 1'b1;
    step();
    clear = 1'b0;
    chain_passfwd = 1'b0;
    model_clear();
    chk("midwait_pulse", chain_clear, 1);
    chk("midwait_done", done, 0);
    chk("midwait_cycles", cycles, 0);
    chk("midwait_ld_ready", ld_ready, 1);
    step();
    chk("midwait_pulse_end", chain_clear, 0);
    chk("midwait_idle", done, 0);

    // async reset in the middle of a readout
    set_tiles(-1);
    kick();
    chain_passfwd = 1'b1;
    step();
    chain_passfwd = 1'b0;
    rd_ready = 1'b1;
    repeat (4) step();
    rd_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rd_valid", rd_valid, 0);
    chk("rst_mid_ld_ready", ld_ready, 1);
    chk("rst_mid_cycles", cycles, 0);
    #1 reset_n = 1'b1;
    model_clear();
    step();
    chk("rst_mid_no_pulse", chain_clear, 0);

    // reload 16 cells including an out-of-range digit
    for (int i = 0; i < 16; i++)
      load((i == 5) ? 3'd6 : 3'($urandom_range(0, 4)), 1'b0);
    chk("reload_ld_ready", ld_ready, 0);
    chk("reload_mask", given_mask, exp_mask());
    chk("reload_value", given_value, exp_value());
    chk("reload_err", err, err_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
